fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the combinational instruction memory. Owns the fetch PC and drives the memory address. Captures each returned word with its PC into a small prefetch FIFO, and presents it to decode over a valid/ready handshake. Handles branch/jump redirects, fetch enable and halt-on-EBREAK.

Parameters:
RESET_PC, 32'h00000000, fetch PC loaded on reset
DEPTH, 2, prefetch FIFO entries; power of two, minimum 2
EBREAK_WORD, 32'h00100073, instruction word that halts fetch

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
fetch_en  in  1  permits fetching while in IDLE/RUN
imem_addr  out  32  address to instruction memory; equals fetch_pc (combinational from register)
imem_instr  in  32  instruction word from memory for imem_addr, valid same cycle
out_valid  out  1  FIFO head holds an instruction
out_ready  in  1  decode accepts head this cycle
out_instr  out  32  head instruction
out_pc  out  32  PC of head instruction
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  32  new fetch PC; bits [1:0] forced to 0
halted  out  1  high in HALTED state
fetch_count  out  32  number of instructions pushed since reset, wraps at 2^32

Behaviour:
- Reset (rst high at a clock edge), regardless of state:
  - fetch_pc=RESET_PC, FIFO count=0, rd/wr pointers=0, state=IDLE, fetch_count=0.
  - Outputs: out_valid=0, halted=0, imem_addr=RESET_PC.
- States:
  - IDLE: no push. Goes to RUN on the next edge when fetch_en=1.
  - RUN: pushes when push_ok. Goes to IDLE when fetch_en=0 (that cycle does not push). Goes to HALTED after pushing EBREAK_WORD.
  - HALTED: no push; halted=1. Leaves only on redirect or rst.
- Definitions: pop = out_valid & out_ready. push_ok = (state==RUN) & fetch_en & (count<DEPTH | pop).
- Push: writes {fetch_pc, imem_instr} at wr_ptr; fetch_pc += 4, wrapping modulo 2^32; fetch_count += 1.
  - If the pushed word == EBREAK_WORD, state becomes HALTED. fetch_pc still advances to EBREAK PC+4.
- Pop: rd_ptr advances.
- Pointers wrap modulo DEPTH.
- Count:
  - push & pop in the same cycle: count unchanged (allowed when full).
  - push only: +1. pop only: -1.
  - Pop never occurs when empty.
- Latency: an instruction is visible on out_* the cycle after its push (registered FIFO), so minimum fetch-to-decode latency is 1 cycle.
- Throughput: 1 instruction/cycle when out_ready is held high.
- out_instr/out_pc hold stable while out_valid=1 & out_ready=0. When out_valid=0 their values are don't-care.
- Redirect (redirect_valid=1) has priority over push and pop bookkeeping:
  - FIFO is flushed: count=0, pointers=0.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - state = RUN if fetch_en=1, else IDLE. This applies from any state, including HALTED.
  - No push that cycle; fetch_count unchanged.
  - A head transfer coinciding with redirect is considered taken by decode; the flush still discards all entries.
  - out_valid=0 the cycle after a redirect. The first redirected instruction appears 2 cycles after the redirect edge.
- rst has priority over redirect.
- fetch_en low does not flush: queued instructions continue to drain to decode.

Test Plan:
- Reset then fetch_en=1, out_ready=1, imem returns addr-derived words:
  - out_pc sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles starting 2 cycles after fetch_en.
  - fetch_count=4 after 4 pushes.
- Backpressure: out_ready=0 for 5 cycles.
  - count stalls at 2 (DEPTH); imem_addr frozen at 0x8; out_pc holds 0x0.
  - After releasing, 0x0, 0x4, 0x8 are delivered in order; none lost or duplicated.
- Full with simultaneous push/pop (out_ready=1 while full):
  - count stays 2; one instruction per cycle; imem_addr advances by 4 each cycle.
- Redirect to 0x103 while the FIFO holds 0x8, 0xC:
  - Next cycle out_valid=0, imem_addr=0x100.
  - Following cycle out_pc=0x100; 0x8/0xC are never delivered.
- EBREAK (32'h00100073) returned at 0x10:
  - Instruction at 0x10 is delivered to decode; halted=1; imem_addr=0x14 and stays there.
  - A later redirect to 0x40 restarts fetch at 0x40 and clears halted.
- rst asserted mid-run with a full FIFO:
  - Next cycle out_valid=0, imem_addr=RESET_PC, fetch_count=0, state IDLE.
  - A redirect asserted in the same cycle as rst is ignored.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, captures {pc, instr} pairs into a
// small prefetch FIFO and hands them to decode over valid/ready.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned DEPTH       = 2,
   parameter logic [31:0] EBREAK_WORD = 32'h0010_0073
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        halted,
   output logic [31:0] fetch_count
);

   localparam int unsigned AW       = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALTED
   } state_t;

   state_t        state;
   logic [31:0]   fetch_pc;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;

   logic [31:0]   mem_pc    [DEPTH];
   logic [31:0]   mem_instr [DEPTH];

   logic pop;
   logic push_ok;
   logic push;
   logic push_ebreak;

   always_comb begin
      pop         = out_valid & out_ready;
      push_ok     = (state == RUN) & fetch_en & ((count < FULL_CNT) | pop);
      push        = push_ok & ~redirect_valid & ~rst;
      push_ebreak = push & (imem_instr == EBREAK_WORD);
   end

   assign imem_addr = fetch_pc;
   assign out_valid = (count != '0);
   assign out_instr = mem_instr[rd_ptr];
   assign out_pc    = mem_pc[rd_ptr];
   assign halted    = (state == HALTED);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr]    <= fetch_pc;
         mem_instr[wr_ptr] <= imem_instr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         fetch_pc    <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         fetch_count <= '0;
      end else if (redirect_valid) begin
         // a head transfer in this cycle is treated as taken; the flush drops the rest
         state    <= fetch_en ? RUN : IDLE;
         fetch_pc <= redirect_pc & ~32'h0000_0003;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            wr_ptr      <= wr_ptr + AW'(1);
            fetch_pc    <= fetch_pc + 32'd4;
            fetch_count <= fetch_count + 32'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         case (state)
            IDLE: begin
               if (fetch_en) state <= RUN;
            end
            RUN: begin
               if (!fetch_en)        state <= IDLE;
               else if (push_ebreak) state <= HALTED;
            end
            HALTED: begin
               state <= HALTED;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table for the sequencing corner cases, then
// randomized traffic against a queue-based reference model.
module tb_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] EBREAK   = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halted;
   logic [31:0] fetch_count;

   logic [31:0] ebreak_addr;

   always #5 clk = ~clk;

   // instruction memory: address-derived words, one programmable EBREAK location
   always_comb imem_instr = (imem_addr == ebreak_addr) ? EBREAK : {8'hA5, imem_addr[23:0]};

   fetch_ctrl #(
      .RESET_PC   (RESET_PC),
      .DEPTH      (DEPTH),
      .EBREAK_WORD(EBREAK)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .fetch_en      (fetch_en),
      .imem_addr     (imem_addr),
      .imem_instr    (imem_instr),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_instr     (out_instr),
      .out_pc        (out_pc),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .halted        (halted),
      .fetch_count   (fetch_count)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: program counter, a queue of delivered-but-unconsumed words, mode flags
   logic [31:0] m_pc;
   logic [31:0] m_fc;
   logic [31:0] q_pc[$];
   logic [31:0] q_in[$];
   bit          m_run;
   bit          m_halt;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == ebreak_addr) ? EBREAK : {8'hA5, a[23:0]};
   endfunction

   task automatic model_update();
      bit          pop;
      bit          can_push;
      logic [31:0] w;
      if (rst) begin
         m_pc = RESET_PC; m_fc = 0; m_run = 0; m_halt = 0;
         q_pc.delete(); q_in.delete();
         return;
      end
      pop = (q_pc.size() != 0) && out_ready;
      if (redirect_valid) begin
         q_pc.delete(); q_in.delete();
         m_pc   = {redirect_pc[31:2], 2'b00};
         m_halt = 0;
         m_run  = fetch_en;
         return;
      end
      can_push = m_run && fetch_en && ((q_pc.size() < DEPTH) || pop);
      if (pop) begin
         void'(q_pc.pop_front());
         void'(q_in.pop_front());
      end
      if (can_push) begin
         w = mem_word(m_pc);
         q_pc.push_back(m_pc);
         q_in.push_back(w);
         m_pc = m_pc + 32'd4;
         m_fc = m_fc + 32'd1;
         if (w == EBREAK) begin
            m_halt = 1;
            m_run  = 0;
         end
      end else if (m_run && !fetch_en) begin
         m_run = 0;
      end else if (!m_run && !m_halt && fetch_en) begin
         m_run = 1;
      end
   endtask

   task automatic model_check();
      chk("model valid", 32'(out_valid), 32'(q_pc.size() != 0));
      if (q_pc.size() != 0) begin
         chk("model out_pc", out_pc, q_pc[0]);
         chk("model out_instr", out_instr, q_in[0]);
      end
      chk("model imem_addr", imem_addr, m_pc);
      chk("model halted", 32'(halted), 32'(m_halt));
      chk("model fetch_count", fetch_count, m_fc);
   endtask

   task automatic step(input logic r, input logic e, input logic rd, input logic rv,
                       input logic [31:0] rp);
      rst = r; fetch_en = e; out_ready = rd; redirect_valid = rv; redirect_pc = rp;
      @(posedge clk);
      model_update();
      @(negedge clk);
      model_check();
   endtask

   typedef struct {
      logic        r, e, rd, rv;
      logic [31:0] rp;
      logic        ev;
      logic [31:0] epc, eaddr;
      logic        eh;
      logic [31:0] efc;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic e, input logic rd, input logic rv,
                      input logic [31:0] rp, input logic ev, input logic [31:0] epc,
                      input logic [31:0] eaddr, input logic eh, input logic [31:0] efc);
      vec_t v;
      v.r = r; v.e = e; v.rd = rd; v.rv = rv; v.rp = rp;
      v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.eh = eh; v.efc = efc;
      tbl.push_back(v);
   endtask

   initial begin
      rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
      redirect_pc = '0; ebreak_addr = 32'h10;

      // straight-line fetch: pcs 0,4,8,C back to back
      add(1,0,1,0,32'h0,   0,32'h0,  32'h0,  0,0);
      add(0,1,1,0,32'h0,   0,32'h0,  32'h0,  0,0);
      add(0,1,1,0,32'h0,   1,32'h0,  32'h4,  0,1);
      add(0,1,1,0,32'h0,   1,32'h4,  32'h8,  0,2);
      add(0,1,1,0,32'h0,   1,32'h8,  32'hC,  0,3);
      add(0,1,1,0,32'h0,   1,32'hC,  32'h10, 0,4);
      add(0,0,1,0,32'h0,   0,32'h0,  32'h10, 0,4);
      // backpressure for 5 cycles, then full with simultaneous push/pop
      add(1,0,0,0,32'h0,   0,32'h0,  32'h0,  0,0);
      add(0,1,0,0,32'h0,   0,32'h0,  32'h0,  0,0);
      add(0,1,0,0,32'h0,   1,32'h0,  32'h4,  0,1);
      add(0,1,0,0,32'h0,   1,32'h0,  32'h8,  0,2);
      add(0,1,0,0,32'h0,   1,32'h0,  32'h8,  0,2);
      add(0,1,0,0,32'h0,   1,32'h0,  32'h8,  0,2);
      add(0,1,0,0,32'h0,   1,32'h0,  32'h8,  0,2);
      add(0,1,1,0,32'h0,   1,32'h4,  32'hC,  0,3);
      add(0,1,1,0,32'h0,   1,32'h8,  32'h10, 0,4);
      // redirect to unaligned 0x103 while 0x8/0xC are queued
      add(0,1,1,1,32'h103, 0,32'h0,  32'h100,0,4);
      add(0,1,1,0,32'h0,   1,32'h100,32'h104,0,5);
      add(0,1,1,0,32'h0,   1,32'h104,32'h108,0,6);
      // run into EBREAK at 0x10, stay halted, restart via redirect to 0x40
      add(0,1,1,1,32'h8,   0,32'h0,  32'h8,  0,6);
      add(0,1,1,0,32'h0,   1,32'h8,  32'hC,  0,7);
      add(0,1,1,0,32'h0,   1,32'hC,  32'h10, 0,8);
      add(0,1,1,0,32'h0,   1,32'h10, 32'h14, 1,9);
      add(0,1,1,0,32'h0,   0,32'h0,  32'h14, 1,9);
      add(0,1,1,0,32'h0,   0,32'h0,  32'h14, 1,9);
      add(0,1,1,1,32'h40,  0,32'h0,  32'h40, 0,9);
      add(0,1,1,0,32'h0,   1,32'h40, 32'h44, 0,10);
      // fill, then reset with a competing redirect
      add(0,1,0,0,32'h0,   1,32'h40, 32'h48, 0,11);
      add(0,1,0,0,32'h0,   1,32'h40, 32'h48, 0,11);
      add(1,1,0,1,32'h200, 0,32'h0,  32'h0,  0,0);
      add(0,1,1,0,32'h0,   0,32'h0,  32'h0,  0,0);
      add(0,1,1,0,32'h0,   1,32'h0,  32'h4,  0,1);

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].e, tbl[i].rd, tbl[i].rv, tbl[i].rp);
         chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
         if (tbl[i].ev) chk($sformatf("row%0d out_pc", i), out_pc, tbl[i].epc);
         chk($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].eaddr);
         chk($sformatf("row%0d halted", i), 32'(halted), 32'(tbl[i].eh));
         chk($sformatf("row%0d fetch_count", i), fetch_count, tbl[i].efc);
      end

      // the EBREAK instruction itself must reach decode intact
      step(0,0,0,1,32'h8);
      step(0,1,0,0,32'h0);
      step(0,1,1,0,32'h0);
      step(0,1,1,0,32'h0);
      step(0,1,1,0,32'h0);
      chk("ebreak out_instr", out_instr, EBREAK);

      ebreak_addr = 32'h30;
      for (int unsigned n = 0; n < 3000; n++) begin
         logic [31:0] rp;
         rp = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : 32'($urandom_range(0, 127));
         step(logic'($urandom_range(0, 199) == 0),
              logic'($urandom_range(0, 9) < 8),
              logic'($urandom_range(0, 9) < 6),
              logic'($urandom_range(0, 19) == 0),
              rp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
